// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM states, default pattern constants and round-robin pick helper
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;
  localparam logic [7:0] PAT_DEF = 8'b0000_0110;
  localparam int PAT_LEN_DEF = 4;
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    rr_pick = ptr;
    for (int k = n - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % n]) rr_pick = 3'((int'(ptr) + k) % n);
  endfunction
endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: Moore serial pattern detector with clearable shift register and fill count
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PAT = PAT_LEN'(PAT_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_in,
  output logic match,
  output logic y
);
  localparam int FW = $clog2(PAT_LEN + 1);
  logic [PAT_LEN-1:0] sr_q, sr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic y_q;
  always_comb begin
    sr_d = {sr_q[PAT_LEN-2:0], bit_in};
    fill_d = (fill_q == FW'(PAT_LEN)) ? fill_q : fill_q + 1'b1;
    match = bit_vld && sr_d == PAT && fill_d == FW'(PAT_LEN);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
      fill_q <= '0;
      y_q <= 1'b0;
    end else if (clr) begin
      sr_q <= '0;
      fill_q <= '0;
      y_q <= 1'b0;
    end else begin
      y_q <= match;
      if (bit_vld) begin
        sr_q <= sr_d;
        fill_q <= fill_d;
      end
    end
  end
  assign y = y_q;
endmodule

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin shares one pattern detector per frame; SEQ_DET_ARB_TIMEOUT_EN adds idle timeout/abort
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int NREQ = 2,
  parameter logic [7:0] PAT = PAT_DEF,
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int CNT_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] bit_in,
  input  logic [NREQ-1:0] bit_vld,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic y,
  output logic done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNT_W-1:0] match_cnt,
  output logic abort
);
  localparam int OW = $clog2(NREQ);
  state_e state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, mc_q, mc_d;
  logic done_q, done_d;
  logic acc, match, fin, to;
  assign acc = state_q == RUN && bit_vld[owner_q];
  assign fin = (acc && last[owner_q]) || to;
  seq_det_core #(.PAT_LEN(PAT_LEN), .PAT(PAT[PAT_LEN-1:0])) u_core (
    .clk(clk),
    .rst(rst),
    .clr(state_q == IDLE),
    .bit_vld(acc),
    .bit_in(bit_in[owner_q]),
    .match(match),
    .y(y)
  );
`ifdef SEQ_DET_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;
  logic abort_q;
  assign to = state_q == RUN && !acc && idle_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      abort_q <= 1'b0;
    end else begin
      idle_q <= (state_q != RUN || acc) ? '0 : idle_q + 1'b1;
      abort_q <= to;
    end
  end
  assign abort = abort_q;
`else
  assign to = 1'b0;
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    mc_d = mc_q;
    id_d = id_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (|req) begin
        owner_d = OW'(rr_pick(8'(req), 3'(rr_q), NREQ));
        gnt_d = '0;
        gnt_d[owner_d] = 1'b1;
        state_d = RUN;
      end
    end
    if (state_q == RUN) begin
      cnt_d = (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      if (fin) begin
        state_d = REPORT;
        gnt_d = '0;
        done_d = 1'b1;
        id_d = owner_q;
        mc_d = cnt_d;
      end
    end
    if (state_q == REPORT) begin
      state_d = IDLE;
      rr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      mc_q <= '0;
      id_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      mc_q <= mc_d;
      id_q <= id_d;
      done_q <= done_d;
    end
  end
  assign gnt = gnt_q;
  assign done = done_q;
  assign done_id = id_q;
  assign match_cnt = mc_q;
endmodule
